// File: rtl/universal_shift_register_burst.sv
// Universal shift register with hold/shift/rotate/load ops and an autonomous
// multi-step burst mode driven by a start/busy/done handshake.
`timescale 1ns/1ps
module universal_shift_register_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_ser_in_r,
  input  logic             i_ser_in_l,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_shift_cnt,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_ser_out_r,
  output logic             o_ser_out_l,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [2:0] ModeHold = 3'b000;
  localparam logic [2:0] ModeShr  = 3'b001;
  localparam logic [2:0] ModeShl  = 3'b010;
  localparam logic [2:0] ModeLoad = 3'b011;
  localparam logic [2:0] ModeRor  = 3'b100;
  localparam logic [2:0] ModeRol  = 3'b101;
  localparam logic [2:0] ModeAsr  = 3'b110;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_remaining;
  logic [2:0]       r_mode;
  logic             r_busy;
  logic             r_done;

  logic             w_is_shift;
  logic [WIDTH-1:0] w_step_idle;
  logic [WIDTH-1:0] w_step_run;

  function automatic logic [WIDTH-1:0] step_op(input logic [2:0]       mode,
                                               input logic [WIDTH-1:0] q,
                                               input logic             sr,
                                               input logic             sl,
                                               input logic [WIDTH-1:0] ld);
    logic [WIDTH-1:0] res;
    res = q;
    case (mode)
      ModeShr:  res = {sr, q[WIDTH-1:1]};
      ModeShl:  res = {q[WIDTH-2:0], sl};
      ModeLoad: res = ld;
      ModeRor:  res = {q[0], q[WIDTH-1:1]};
      ModeRol:  res = {q[WIDTH-2:0], q[WIDTH-1]};
      ModeAsr:  res = {q[WIDTH-1], q[WIDTH-1:1]};
      default:  res = q;
    endcase
    return res;
  endfunction

  always_comb begin
    w_is_shift = (i_mode == ModeShr) || (i_mode == ModeShl) || (i_mode == ModeRor) ||
                 (i_mode == ModeRol) || (i_mode == ModeAsr);
  end

  assign w_step_idle = step_op(i_mode, r_data, i_ser_in_r, i_ser_in_l, i_data_in);
  // In RUN the latched mode drives the step; LOAD never reaches here, so data_in is unused.
  assign w_step_run  = step_op(r_mode, r_data, i_ser_in_r, i_ser_in_l, r_data);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_data      <= '0;
      r_remaining <= '0;
      r_mode      <= ModeHold;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_en) begin
            if (i_start && w_is_shift) begin
              if (i_shift_cnt == '0) begin
                r_done <= 1'b1;
              end else if (i_shift_cnt == CNT_W'(1)) begin
                r_data <= w_step_idle;
                r_done <= 1'b1;
              end else begin
                r_data      <= w_step_idle;
                r_remaining <= i_shift_cnt - CNT_W'(1);
                r_mode      <= i_mode;
                r_busy      <= 1'b1;
                r_state     <= StRun;
              end
            end else begin
              r_data <= w_step_idle;
            end
          end
        end
        StRun: begin
          // en low stalls the burst with everything held.
          if (i_en) begin
            r_data <= w_step_run;
            if (r_remaining == CNT_W'(1)) begin
              r_remaining <= '0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= StIdle;
            end else begin
              r_remaining <= r_remaining - CNT_W'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_data_out  = r_data;
  assign o_ser_out_r = r_data[0];
  assign o_ser_out_l = r_data[WIDTH-1];
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_universal_shift_register_burst.sv
// Scoreboard bench: driver pushes model predictions per edge, monitor pops and
// compares the registered outputs shortly after each rising edge.
`timescale 1ns/1ps
module tb_universal_shift_register_burst;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] din;
  logic         sr;
  logic         sl;
  logic         start;
  logic [3:0]   cnt;
  logic [W-1:0] dout;
  logic         sor;
  logic         sol;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  universal_shift_register_burst #(.WIDTH(W), .CNT_W(4)) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_en       (en),
    .i_mode     (mode),
    .i_data_in  (din),
    .i_ser_in_r (sr),
    .i_ser_in_l (sl),
    .i_start    (start),
    .i_shift_cnt(cnt),
    .o_data_out (dout),
    .o_ser_out_r(sor),
    .o_ser_out_l(sol),
    .o_busy     (busy),
    .o_done     (done)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         b;
    logic         dn;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: register value plus "steps still owed" for an active burst.
  int   m_q;
  int   m_left;
  int   m_mode;
  bit   m_done;

  function automatic int ref_step(int m, int q, int s_r, int s_l, int ld);
    case (m)
      1:       return (q / 2) + s_r * 128;
      2:       return ((q * 2) % 256) + s_l;
      3:       return ld;
      4:       return (q / 2) + (q % 2) * 128;
      5:       return ((q * 2) % 256) + (q / 128);
      6:       return (q / 2) + (q / 128) * 128;
      default: return q;
    endcase
  endfunction

  function automatic bit is_shift_mode(int m);
    return m == 1 || m == 2 || m == 4 || m == 5 || m == 6;
  endfunction

  task automatic model_edge();
    bit nd = 0;
    if (!rst_n) begin
      m_q = 0; m_left = 0; m_mode = 0; m_done = 0;
      return;
    end
    if (m_left > 0) begin
      if (en) begin
        m_q = ref_step(m_mode, m_q, int'(sr), int'(sl), 0);
        m_left--;
        if (m_left == 0) nd = 1;
      end
    end else if (en) begin
      if (start && is_shift_mode(int'(mode))) begin
        if (cnt == 0) nd = 1;
        else begin
          m_q    = ref_step(int'(mode), m_q, int'(sr), int'(sl), 0);
          m_left = int'(cnt) - 1;
          m_mode = int'(mode);
          if (m_left == 0) nd = 1;
        end
      end else begin
        m_q = ref_step(int'(mode), m_q, int'(sr), int'(sl), int'(din));
      end
    end
    m_done = nd;
  endtask

  task automatic drive(input bit r, input bit e, input int m, input int d, input bit s_r,
                       input bit s_l, input bit st, input int c);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; mode = 3'(m); din = W'(d); sr = s_r; sl = s_l; start = st; cnt = 4'(c);
    model_edge();
    x.d  = W'(m_q);
    x.b  = (m_left > 0);
    x.dn = m_done;
    sb.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("data_out", 32'(dout), 32'(mon_e.d));
      chk("busy", 32'(busy), 32'(mon_e.b));
      chk("done", 32'(done), 32'(mon_e.dn));
      chk("ser_out_r", 32'(sor), 32'(mon_e.d[0]));
      chk("ser_out_l", 32'(sol), 32'(mon_e.d[W-1]));
    end
  end

  task automatic op(input int m, input int d, input bit s_l);
    drive(1, 1, m, d, 0, s_l, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; en = 0; mode = 0; din = 0; sr = 0; sl = 0; start = 0; cnt = 0;
    m_q = 0; m_left = 0; m_mode = 0; m_done = 0;

    // Reset with random inputs, then basic ops from 8'hA5.
    for (int i = 0; i < 2; i++)
      drive(0, 1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
    op(3, 'hA5, 0);
    op(4, 0, 0);
    op(5, 0, 0);
    op(6, 0, 0);
    op(3, 'hA5, 0);
    op(2, 0, 1);

    // ROL burst of 3 from 8'h81.
    op(3, 'h81, 0);
    drive(1, 1, 5, 0, 0, 0, 1, 3);
    idle(3);

    // SHR burst of 5 with a two-cycle stall.
    op(3, 'h3C, 0);
    drive(1, 1, 1, 0, 1, 0, 1, 5);
    drive(1, 1, 3, 'hFF, 0, 0, 1, 2);
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 1'(i), 0, 0, 0);
    idle(2);

    // Zero-length burst, then start with LOAD mode.
    drive(1, 1, 1, 0, 1, 0, 1, 0);
    drive(1, 1, 3, 'h5A, 0, 0, 1, 4);
    idle(2);

    // ROR burst of 9 abandoned by reset after 4 steps.
    op(3, 'hC3, 0);
    drive(1, 1, 4, 0, 0, 0, 1, 9);
    idle(3);
    drive(0, 1, 4, 0, 0, 0, 1, 9);
    idle(3);

    // Back-to-back start on the done cycle.
    op(3, 'h96, 0);
    drive(1, 1, 6, 0, 0, 0, 1, 2);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 2, 0, 0, 1, 1, 3);
    idle(4);

    // Randomised traffic.
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 99) >= 2, $urandom_range(0, 99) < 85,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            1'($urandom), 1'($urandom), $urandom_range(0, 99) < 25,
            int'($urandom_range(0, 15)));

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
